// File: rtl/dmem_pkg.sv
// Shared sizing and types for the word-addressed data memory.
package dmem_pkg;

    localparam int DMEM_ADDR_WIDTH = 9;
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_DEPTH      = 512;

    typedef logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_t;
    typedef logic [DMEM_DATA_WIDTH-1:0] dmem_word_t;

    localparam dmem_addr_t DMEM_ZERO_ADDR = '0;

endpackage

// File: rtl/dmem_wdec.sv
// One-hot per-word write enables; word 0 never gets an enable.
module dmem_wdec
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DEPTH      = DMEM_DEPTH
) (
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DEPTH-1:0]      wordEnable
);

    always_comb begin
        wordEnable = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wordEnable[i] = (writeAddress == ADDR_WIDTH'(i));
        end
    end

endmodule

// File: rtl/data_mem.sv
// Data memory: combinational read port, enable-less synchronous write port,
// word 0 hardwired to zero so an idle store parks on address 0.
module data_mem
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0] readData,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic [DATA_WIDTH-1:0] writeData
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(DMEM_ZERO_ADDR);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      wordEnable;

    dmem_wdec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) wdec (
        .writeAddress (writeAddress),
        .wordEnable   (wordEnable)
    );

    // Reset clears every word and drops any write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wordEnable[i]) begin
                    mem[i] <= writeData;
                end
            end
        end
    end

    always_comb begin
        readData = '0;
        if (readAddress != ZERO_ADDR) begin
            readData = mem[readAddress];
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, hand sequences, random vs. array model.
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic [8:0]  readAddress;
    logic [31:0] readData;
    logic [8:0]  writeAddress;
    logic [31:0] writeData;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [512];

    typedef struct {
        string       name;
        logic        r;
        logic [8:0]  wa;
        logic [31:0] wd;
        logic [8:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    data_mem dut (
        .clk          (clk),
        .rst          (rst),
        .readAddress  (readAddress),
        .readData     (readData),
        .writeAddress (writeAddress),
        .writeData    (writeData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic r, input logic [8:0] wa,
                          input logic [31:0] wd, input logic [8:0] ra,
                          input logic [31:0] exp);
        vec_t v;
        v.name = name;
        v.r = r;
        v.wa = wa;
        v.wd = wd;
        v.ra = ra;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] modelRead(input logic [8:0] a);
        return (a == 9'd0) ? 32'd0 : model[a];
    endfunction

    task automatic modelEdge(input logic r, input logic [8:0] wa,
                             input logic [31:0] wd);
        if (r) begin
            foreach (model[i]) model[i] = 32'd0;
        end else if (wa != 9'd0) begin
            model[wa] = wd;
        end
    endtask

    initial begin
        rst = 1'b0;
        readAddress = '0;
        writeAddress = '0;
        writeData = '0;
        #1;

        addVec("rst_ra0",    1'b1, 9'd0,   32'd0,          9'd0,   32'd0);
        addVec("rst_ra1",    1'b0, 9'd0,   32'd0,          9'd1,   32'd0);
        addVec("rst_ra255",  1'b0, 9'd0,   32'd0,          9'd255, 32'd0);
        addVec("rst_ra511",  1'b0, 9'd0,   32'd0,          9'd511, 32'd0);
        addVec("wr10",       1'b0, 9'd10,  32'd12345,      9'd10,  32'd12345);
        addVec("wr11_rd10",  1'b0, 9'd11,  32'd6789,       9'd10,  32'd12345);
        addVec("rd11",       1'b0, 9'd0,   32'd0,          9'd11,  32'd6789);
        addVec("wr1",        1'b0, 9'd1,   32'd1,          9'd1,   32'd1);
        addVec("wr0_rd0",    1'b0, 9'd0,   32'hDEADBEEF,   9'd0,   32'd0);
        addVec("addr1_keep", 1'b0, 9'd0,   32'd0,          9'd1,   32'd1);
        addVec("wr20",       1'b0, 9'd20,  32'd5,          9'd20,  32'd5);
        addVec("wr511_ones", 1'b0, 9'd511, 32'hFFFFFFFF,   9'd511, 32'hFFFFFFFF);
        addVec("wr511_one",  1'b0, 9'd511, 32'h00000001,   9'd511, 32'h00000001);
        addVec("addr255",    1'b0, 9'd0,   32'd0,          9'd255, 32'd0);
        addVec("addr10",     1'b0, 9'd0,   32'd0,          9'd10,  32'd12345);

        foreach (vecs[i]) begin
            rst = vecs[i].r;
            writeAddress = vecs[i].wa;
            writeData = vecs[i].wd;
            readAddress = vecs[i].ra;
            tick();
            check(vecs[i].name, readData, vecs[i].exp);
        end
        rst = 1'b0;
        writeAddress = '0;
        writeData = '0;

        // Same-address read/write: old value before the edge, new after
        readAddress = 9'd20;
        writeAddress = 9'd20;
        writeData = 32'd77;
        #1;
        check("raw_before", readData, 32'd5);
        tick();
        check("raw_after", readData, 32'd77);
        writeAddress = '0;

        // Reset on the same edge as a write: reset wins
        rst = 1'b1;
        writeAddress = 9'd30;
        writeData = 32'd42;
        tick();
        rst = 1'b0;
        writeAddress = '0;
        writeData = '0;
        readAddress = 9'd30;  #1; check("rstwin_30",  readData, 32'd0);
        readAddress = 9'd10;  #1; check("rstwin_10",  readData, 32'd0);
        readAddress = 9'd20;  #1; check("rstwin_20",  readData, 32'd0);
        readAddress = 9'd511; #1; check("rstwin_511", readData, 32'd0);
        readAddress = 9'd1;   #1; check("rstwin_1",   readData, 32'd0);

        foreach (model[i]) model[i] = 32'd0;

        // Random traffic against the array model
        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic [8:0]  wa;
            logic [8:0]  ra;
            logic [31:0] wd;
            r = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0: wa = 9'd0;
                1: wa = 9'(($urandom_range(0, 1) == 0) ? 9'd511 : 9'd1);
                2: wa = 9'($urandom_range(0, 15));
                default: wa = 9'($urandom);
            endcase
            wd = $urandom;
            case ($urandom_range(0, 2))
                0: ra = wa;
                1: ra = 9'($urandom_range(0, 15));
                default: ra = 9'($urandom);
            endcase
            rst = r;
            writeAddress = wa;
            writeData = wd;
            readAddress = ra;
            #1;
            check("rand_pre", readData, modelRead(ra));
            tick();
            modelEdge(r, wa, wd);
            check("rand_post", readData, modelRead(ra));
        end

        rst = 1'b0;
        writeAddress = '0;
        for (int a = 0; a < 512; a += 37) begin
            readAddress = 9'(a);
            #1;
            check("sweep", readData, modelRead(9'(a)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
